rv_ctl: RTL and testbench

RV_CTL -- requirements
Module: rv_ctl

---
 rtl/rv_ctl.sv | 239 +++++++++++++++++++++++
 tb/tb_rv_ctl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl.sv
// Multi-cycle RISC-V control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps and drives the datapath selects and
// enables. The ready handshakes and the branch zero flag act combinationally
// on the current state's outputs. A retired-instruction counter also lives here.
module rv_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pcsourse,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic [1:0]  wbsel,
  output logic        regwen,
  output logic [1:0]  immsel,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alusel,
  output logic        mdrwrite,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        halt,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ADDR, MEM_RD, MEM_WR, WB_MEM, JALR2, ERROR
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] WB_MDR = 2'd0, WB_ALUOUT = 2'd1, WB_PC = 2'd2;
  localparam logic [1:0] IMM_J = 2'd0, IMM_B = 2'd1, IMM_S = 2'd2, IMM_L = 2'd3;
  localparam logic [1:0] A_PCC = 2'd0, A_REG = 2'd1, A_ALUOUT = 2'd2;
  localparam logic [1:0] B_IMM = 2'd0, B_REG = 2'd1, B_CONST = 2'd2;

  state_t state, next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       taken;
  logic       unused_instr;

  logic pcwrite_c, pccen_c, irwrite_c, regwen_c, mdrwrite_c;
  logic dmem_re_c, dmem_we_c, halt_c;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign alt          = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Branch condition: even funct3 takes on the flag's own sense (zero for
  // SUB, !zero for SLT/SLTU), odd funct3 takes on the inverse.
  assign taken = funct3[0] ^ (funct3[2] ? ~zero : zero);

  // ALU operation for register/immediate arithmetic; sub_sra picks SUB or SRA.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  arith_op = sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Next-state and datapath control decode for the current state.
  always_comb begin
    next       = state;
    pcsourse   = 1'b0;
    wbsel      = WB_MDR;
    immsel     = IMM_J;
    asel       = A_ALUOUT;
    bsel       = B_CONST;
    alusel     = ALU_AND;
    pcwrite_c  = 1'b0;
    pccen_c    = 1'b0;
    irwrite_c  = 1'b0;
    regwen_c   = 1'b0;
    mdrwrite_c = 1'b0;
    dmem_re_c  = 1'b0;
    dmem_we_c  = 1'b0;
    halt_c     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          pccen_c   = 1'b1;
          next      = DECODE;
        end
      end
      DECODE: begin
        asel   = A_PCC;
        bsel   = B_IMM;
        alusel = ALU_ADD;
        immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR: next = EXEC;
          OP_LOAD, OP_STORE:                      next = ADDR;
          default:                                next = ERROR;
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_R: begin
            asel   = A_REG;
            bsel   = B_REG;
            alusel = arith_op(funct3, alt);
            next   = WB_MEM;
          end
          OP_I: begin
            asel   = A_REG;
            bsel   = B_IMM;
            immsel = IMM_L;
            alusel = arith_op(funct3, alt && (funct3 == 3'b101));
            next   = WB_MEM;
          end
          OP_BRANCH: begin
            asel = A_REG;
            bsel = B_REG;
            case (funct3)
              3'b000, 3'b001: alusel = ALU_SUB;
              3'b100, 3'b101: alusel = ALU_SLT;
              3'b110, 3'b111: alusel = ALU_SLTU;
              default:        alusel = ALU_AND;
            endcase
            if (funct3[2:1] == 2'b01) begin
              next = ERROR;
            end else begin
              if (taken) begin
                pcwrite_c = 1'b1;
                pcsourse  = 1'b1;
              end
              next = FETCH;
            end
          end
          OP_JAL: begin
            regwen_c  = 1'b1;
            wbsel     = WB_PC;
            pcwrite_c = 1'b1;
            pcsourse  = 1'b1;
            next      = FETCH;
          end
          OP_JALR: begin
            asel   = A_REG;
            bsel   = B_IMM;
            immsel = IMM_L;
            alusel = ALU_ADD;
            next   = JALR2;
          end
          default: next = ERROR;
        endcase
      end
      ADDR: begin
        asel   = A_REG;
        bsel   = B_IMM;
        alusel = ALU_ADD;
        immsel = (opcode == OP_LOAD) ? IMM_L : IMM_S;
        next   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        dmem_re_c = 1'b1;
        if (dmem_ready) begin
          mdrwrite_c = 1'b1;
          next       = WB_MEM;
        end
      end
      MEM_WR: begin
        dmem_we_c = 1'b1;
        if (dmem_ready) next = FETCH;
      end
      WB_MEM: begin
        regwen_c = 1'b1;
        wbsel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        next     = FETCH;
      end
      JALR2: begin
        regwen_c  = 1'b1;
        wbsel     = WB_PC;
        pcwrite_c = 1'b1;
        pcsourse  = 1'b1;
        next      = FETCH;
      end
      ERROR: begin
        halt_c = 1'b1;
      end
      default: next = ERROR;
    endcase
  end

  // Enables, strobes and halt are forced low while reset is held, so an
  // aborted instruction cannot write anything even in the reset cycle itself.
  assign pcwrite  = rst & pcwrite_c;
  assign pccen    = rst & pccen_c;
  assign irwrite  = rst & irwrite_c;
  assign regwen   = rst & regwen_c;
  assign mdrwrite = rst & mdrwrite_c;
  assign dmem_re  = rst & dmem_re_c;
  assign dmem_we  = rst & dmem_we_c;
  assign halt     = rst & halt_c;

  // State register and retired-instruction counter; a retirement is any
  // entry into FETCH from another state (stalling in FETCH does not count).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      instret <= 32'd0;
    end else begin
      state <= next;
      if (next == FETCH && state != FETCH) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv_ctl.sv
// Self-checking bench for rv_ctl: walks instructions step by step, predicting
// every cycle's controls from the instruction class and random ready stalls.
module tb_rv_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, imem_ready, dmem_ready;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
  logic        dmem_re, dmem_we, halt;
  logic [1:0]  wbsel, immsel, asel, bsel;
  logic [3:0]  alusel;
  logic [31:0] instret;

  rv_ctl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
    .alusel(alusel), .mdrwrite(mdrwrite), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .halt(halt), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcsourse, pcwrite, pccen, irwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [1:0] immsel, asel, bsel;
    logic [3:0] alusel;
    logic       mdrwrite, dmem_re, dmem_we, halt;
  } ctl_t;

  ctl_t obs;
  assign obs = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
                asel, bsel, alusel, mdrwrite, dmem_re, dmem_we, halt};

  int          testsRun = 0;
  int          failCount = 0;
  int          maxStall = 2;
  int          zeroForce = -1;
  logic [31:0] modelRet = 32'd0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Idle control word: nothing enabled, ALU holding its output.
  function automatic ctl_t idleCtl();
    ctl_t c;
    c = '0;
    c.asel = 2'd2;
    c.bsel = 2'd2;
    c.alusel = 4'd9;
    return c;
  endfunction

  // Mnemonic-level ALU choice for arithmetic instructions.
  function automatic logic [3:0] aluModel(input logic [2:0] f3, input logic subOrSra);
    case (f3)
      3'd0:    return subOrSra ? 4'd1 : 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return subOrSra ? 4'd7 : 4'd6;
      3'd6:    return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  // Inputs already driven at this negedge; check just after, then advance.
  task automatic cycleCheck(input string tag, input ctl_t e);
    #1;
    checkOutput(tag, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic fetchStep();
    ctl_t e;
    int n;
    checkOutput("instret", instret, modelRet);
    n = $urandom_range(0, maxStall);
    repeat (n) begin
      imem_ready = 1'b0;
      cycleCheck("fetch_stall", idleCtl());
    end
    imem_ready = 1'b1;
    e = idleCtl();
    e.irwrite = 1'b1;
    e.pcwrite = 1'b1;
    e.pccen = 1'b1;
    cycleCheck("fetch", e);
    imem_ready = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checkOutput("reset_ctl", 32'(obs), 32'(idleCtl()));
    checkOutput("reset_instret", instret, 32'd0);
    modelRet = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    cycleCheck("post_reset_wait", idleCtl());
  endtask

  task automatic checkHalted();
    ctl_t e;
    e = idleCtl();
    e.halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      cycleCheck("halted", e);
    end
    applyReset();
  endtask

  // Walk one instruction from fetch to retirement (or to halt).
  task automatic applyStimulus(input logic [31:0] ins, input int stalls);
    ctl_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic taken;
    int n;
    op = ins[6:0];
    f3 = ins[14:12];
    n = (stalls < 0) ? int'($urandom_range(0, 3)) : stalls;
    fetchStep();
    instr = ins;
    e = idleCtl();
    e.asel = 2'd0;
    e.bsel = 2'd0;
    e.alusel = 4'd0;
    e.immsel = (op == JAL) ? 2'd0 : 2'd1;
    cycleCheck("decode", e);
    case (op)
      R, I: begin
        e = idleCtl();
        e.asel = 2'd1;
        e.bsel = (op == R) ? 2'd1 : 2'd0;
        if (op == I) e.immsel = 2'd3;
        e.alusel = aluModel(f3, (op == R) ? ins[30] : (f3 == 3'd5 && ins[30]));
        cycleCheck("exec_alu", e);
        e = idleCtl();
        e.wbsel = 2'd1;
        e.regwen = 1'b1;
        cycleCheck("wb_alu", e);
        modelRet++;
      end
      BR: begin
        e = idleCtl();
        e.asel = 2'd1;
        e.bsel = 2'd1;
        if (f3 == 3'd2 || f3 == 3'd3) begin
          cycleCheck("exec_badbranch", e);
          checkHalted();
        end else begin
          zero = (zeroForce < 0) ? 1'($urandom_range(0, 1)) : 1'(zeroForce);
          case (f3)
            3'd0, 3'd5, 3'd7: taken = zero;
            default:          taken = !zero;
          endcase
          e.alusel = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd3 : 4'd4;
          e.pcwrite = taken;
          e.pcsourse = taken;
          cycleCheck("exec_branch", e);
          modelRet++;
        end
      end
      JAL, JALR: begin
        if (op == JALR) begin
          e = idleCtl();
          e.asel = 2'd1;
          e.bsel = 2'd0;
          e.immsel = 2'd3;
          e.alusel = 4'd0;
          cycleCheck("exec_jalr", e);
        end
        e = idleCtl();
        e.regwen = 1'b1;
        e.wbsel = 2'd2;
        e.pcwrite = 1'b1;
        e.pcsourse = 1'b1;
        cycleCheck("link_jump", e);
        modelRet++;
      end
      LD, ST: begin
        e = idleCtl();
        e.asel = 2'd1;
        e.bsel = 2'd0;
        e.alusel = 4'd0;
        e.immsel = (op == LD) ? 2'd3 : 2'd2;
        cycleCheck("addr", e);
        e = idleCtl();
        if (op == LD) e.dmem_re = 1'b1;
        else e.dmem_we = 1'b1;
        repeat (n) begin
          dmem_ready = 1'b0;
          cycleCheck("mem_stall", e);
        end
        dmem_ready = 1'b1;
        if (op == LD) e.mdrwrite = 1'b1;
        cycleCheck("mem_done", e);
        dmem_ready = 1'b0;
        if (op == LD) begin
          e = idleCtl();
          e.regwen = 1'b1;
          e.wbsel = 2'd0;
          cycleCheck("wb_mem", e);
        end
        modelRet++;
      end
      default: checkHalted();
    endcase
  endtask

  // A store interrupted by reset while waiting on the data memory.
  task automatic resetDuringStore();
    ctl_t e;
    fetchStep();
    instr = 32'h0020a223;
    e = idleCtl();
    e.asel = 2'd0; e.bsel = 2'd0; e.alusel = 4'd0; e.immsel = 2'd1;
    cycleCheck("decode_sw", e);
    e = idleCtl();
    e.asel = 2'd1; e.bsel = 2'd0; e.alusel = 4'd0; e.immsel = 2'd2;
    cycleCheck("addr_sw", e);
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    e = idleCtl();
    e.dmem_we = 1'b1;
    #1 checkOutput("memwr_before_rst", 32'(obs), 32'(e));
    #2 rst = 1'b0;
    #1 checkOutput("memwr_rst_ctl", 32'(obs), 32'(idleCtl()));
    checkOutput("memwr_rst_instret", instret, 32'd0);
    modelRet = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b1;
    cycleCheck("after_abort", idleCtl());
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  badOps [5];
    int          k;
    badOps = '{7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111, 7'b0000000};
    rst = 1'b0;
    instr = 32'd0;
    zero = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    applyReset();

    maxStall = 0;
    applyStimulus(32'h002081B3, 0);
    maxStall = 2;
    applyStimulus(32'h0000A183, 3);
    zeroForce = 1;
    applyStimulus(32'h00000063, 0);
    applyStimulus(32'h00001063, 0);
    zeroForce = -1;

    for (int t = 0; t < 80; t++) begin
      ins = $urandom;
      k = $urandom_range(0, 15);
      case (k)
        0, 1, 2:  ins[6:0] = R;
        3, 4, 5:  ins[6:0] = I;
        6, 7, 8:  ins[6:0] = BR;
        9:        ins[6:0] = JAL;
        10:       ins[6:0] = JALR;
        11, 12:   ins[6:0] = LD;
        13, 14:   ins[6:0] = ST;
        default:  ins[6:0] = badOps[$urandom_range(0, 4)];
      endcase
      applyStimulus(ins, -1);
    end

    resetDuringStore();

    imem_ready = 1'b0;
    force dut.instret = 32'hffff_ffff;
    #1 release dut.instret;
    modelRet = 32'hffff_ffff;
    @(negedge clk);
    applyStimulus(32'h002081B3, 0);
    checkOutput("instret_wrap", instret, 32'd0);

    applyStimulus(32'h000001B7, 0);
    fetchStep();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
